// File: rtl/rx_bd_pkg.sv
// Shared constants for the PSK receiver boundary detector: FSM state codes,
// symbol classes and the lane-masked symbol classifier.
package rx_bd_pkg;

  typedef logic [1:0] state_t;
  typedef logic [1:0] sym_cls_t;

  localparam state_t StIdle    = 2'd0;
  localparam state_t StSearch  = 2'd1;
  localparam state_t StConfirm = 2'd2;
  localparam state_t StLocked  = 2'd3;

  localparam sym_cls_t ClsToggle = 2'd0;
  localparam sym_cls_t ClsHold   = 2'd1;
  localparam sym_cls_t ClsMixed  = 2'd2;

  // diff is {Q,I} XOR previous {Q,I}; the Q lane only counts in QPSK.
  function automatic sym_cls_t classify(input logic [1:0] diff, input logic qpsk);
    sym_cls_t cls;
    if (!qpsk) begin
      cls = diff[0] ? ClsToggle : ClsHold;
    end else if (diff == 2'b11) begin
      cls = ClsToggle;
    end else if (diff == 2'b00) begin
      cls = ClsHold;
    end else begin
      cls = ClsMixed;
    end
    return cls;
  endfunction

endpackage

// File: rtl/rx_bd_sym_cls.sv
// Previous-symbol register plus TOGGLE/HOLD/MIXED classification of the
// current symbol against it.
module rx_bd_sym_cls
  import rx_bd_pkg::*;
(
  input  logic     clk,
  input  logic     rst,
  input  logic     mode_qpsk,
  input  logic     sym_vld,
  input  logic     sym_i,
  input  logic     sym_q,
  output sym_cls_t cls
);

  logic [1:0] prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q <= 2'b00;
    end else if (sym_vld) begin
      prev_q <= {sym_q, sym_i};
    end
  end

  assign cls = classify({sym_q, sym_i} ^ prev_q, mode_qpsk);

endmodule

// File: rtl/rx_bd_multi.sv
// Packet boundary detector: finds the polarity-inversion symbol in the TRN
// field, confirms it over a window with an error budget, then counts payload.
module rx_bd_multi
  import rx_bd_pkg::*;
#(
  parameter int unsigned CNT_W = 8,
  parameter int unsigned IDX_W = 12
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             mode_qpsk,
  input  logic [CNT_W-1:0] cfg_min_trn,
  input  logic [CNT_W-1:0] cfg_window,
  input  logic [CNT_W-1:0] cfg_err_max,
  input  logic [IDX_W-1:0] cfg_pkt_len,
  input  logic             sym_vld,
  input  logic             sym_i,
  input  logic             sym_q,
  input  logic             pd_flag,
  input  logic             disassert_bd,
  output logic             bd_init,
  output logic             bd_flag,
  output logic             bd_abort,
  output logic [1:0]       bd_sgn,
  output logic [IDX_W-1:0] sym_idx,
  output logic             pkt_done
);

  localparam logic [CNT_W-1:0] CntOne = 1;
  localparam logic [IDX_W-1:0] IdxOne = 1;

  sym_cls_t cls;

  rx_bd_sym_cls u_sym_cls (
    .clk       (clk),
    .rst       (rst),
    .mode_qpsk (mode_qpsk),
    .sym_vld   (sym_vld),
    .sym_i     (sym_i),
    .sym_q     (sym_q),
    .cls       (cls)
  );

  state_t           state_q, state_d;
  logic [CNT_W-1:0] trn_cnt_q, trn_cnt_d;
  logic [CNT_W-1:0] win_cnt_q, win_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             init_q, init_d;
  logic             flag_q, flag_d;
  logic             abort_q, abort_d;
  logic [1:0]       sgn_q, sgn_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic [CNT_W-1:0] win_inc;
  logic [CNT_W-1:0] err_inc;
  logic [IDX_W-1:0] idx_last;

  assign win_inc  = win_cnt_q + CntOne;
  assign err_inc  = (cls != ClsToggle && err_cnt_q != '1) ? err_cnt_q + CntOne : err_cnt_q;
  assign idx_last = cfg_pkt_len - IdxOne;

  always_comb begin
    state_d   = state_q;
    trn_cnt_d = trn_cnt_q;
    win_cnt_d = win_cnt_q;
    err_cnt_d = err_cnt_q;
    init_d    = 1'b0;
    abort_d   = 1'b0;
    done_d    = 1'b0;
    flag_d    = flag_q;
    sgn_d     = sgn_q;
    idx_d     = idx_q;

    if (!pd_flag || disassert_bd) begin
      // Overrides act on any cycle, regardless of sym_vld.
      state_d   = pd_flag ? StSearch : StIdle;
      flag_d    = 1'b0;
      sgn_d     = 2'b00;
      idx_d     = '0;
      trn_cnt_d = '0;
      win_cnt_d = '0;
      err_cnt_d = '0;
    end else begin
      case (state_q)
        StIdle: begin
          state_d = StSearch;
        end
        StSearch: begin
          if (sym_vld) begin
            case (cls)
              ClsToggle: begin
                if (trn_cnt_q != '1) trn_cnt_d = trn_cnt_q + CntOne;
              end
              ClsHold: begin
                if (trn_cnt_q >= cfg_min_trn) begin
                  init_d    = 1'b1;
                  sgn_d     = {mode_qpsk & sym_q, sym_i};
                  win_cnt_d = '0;
                  err_cnt_d = '0;
                  // A zero-length window locks on the boundary symbol itself.
                  if (cfg_window == '0) begin
                    flag_d  = 1'b1;
                    idx_d   = '0;
                    state_d = StLocked;
                  end else begin
                    state_d = StConfirm;
                  end
                end else begin
                  trn_cnt_d = '0;
                end
              end
              default: begin
                trn_cnt_d = '0;
              end
            endcase
          end
        end
        StConfirm: begin
          if (sym_vld) begin
            win_cnt_d = win_inc;
            err_cnt_d = err_inc;
            if (err_inc > cfg_err_max) begin
              abort_d   = 1'b1;
              sgn_d     = 2'b00;
              trn_cnt_d = '0;
              state_d   = StSearch;
            end else if (win_inc == cfg_window) begin
              flag_d  = 1'b1;
              idx_d   = '0;
              state_d = StLocked;
            end
          end
        end
        StLocked: begin
          if (sym_vld) begin
            if (cfg_pkt_len != '0 && idx_q == idx_last) begin
              done_d    = 1'b1;
              flag_d    = 1'b0;
              idx_d     = '0;
              trn_cnt_d = '0;
              state_d   = StSearch;
            end else begin
              idx_d = idx_q + IdxOne;
            end
          end
        end
        default: begin
          state_d = StIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      trn_cnt_q <= '0;
      win_cnt_q <= '0;
      err_cnt_q <= '0;
      init_q    <= 1'b0;
      flag_q    <= 1'b0;
      abort_q   <= 1'b0;
      sgn_q     <= 2'b00;
      idx_q     <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      trn_cnt_q <= trn_cnt_d;
      win_cnt_q <= win_cnt_d;
      err_cnt_q <= err_cnt_d;
      init_q    <= init_d;
      flag_q    <= flag_d;
      abort_q   <= abort_d;
      sgn_q     <= sgn_d;
      idx_q     <= idx_d;
      done_q    <= done_d;
    end
  end

  assign bd_init  = init_q;
  assign bd_flag  = flag_q;
  assign bd_abort = abort_q;
  assign bd_sgn   = sgn_q;
  assign sym_idx  = idx_q;
  assign pkt_done = done_q;

endmodule

// File: doc/rx_bd_multi.md
Name: rx_bd_multi

Overview:
- Second-generation packet boundary detector for the PSK receiver.
- Searches the alternating TRN field for the polarity-inversion symbol and qualifies it with a minimum preamble length, a confirmation window and an error budget.
- Supports BPSK (I lane) or QPSK (I and Q lanes), and a symbol-valid strobe.
- Tracks payload symbol index and self-terminates after a configurable packet length; sits between PD (packet detect) and the deframer.

Parameters:
- CNT_W, 8: width of the TRN counter, window counter and error counter, and of the config inputs that feed them.
- IDX_W, 12: width of the packet-length config and the symbol-index counter.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-high
- mode_qpsk  in  1  0 = BPSK (I lane only), 1 = QPSK (I and Q lanes)
- cfg_min_trn  in  CNT_W  minimum consecutive toggles before a hold is accepted
- cfg_window  in  CNT_W  confirmation window length, in symbols
- cfg_err_max  in  CNT_W  maximum non-toggles tolerated inside the window
- cfg_pkt_len  in  IDX_W  payload symbols per packet; 0 = no auto-termination
- sym_vld  in  1  symbol strobe
- sym_i  in  1  hard-decision I bit
- sym_q  in  1  hard-decision Q bit
- pd_flag  in  1  packet-detect level
- disassert_bd  in  1  external abort / end of packet
- bd_init  out  1  1-cycle pulse: candidate boundary found
- bd_flag  out  1  level: boundary confirmed (locked)
- bd_abort  out  1  1-cycle pulse: candidate rejected
- bd_sgn  out  2  {Q,I} symbol at the boundary
- sym_idx  out  IDX_W  payload symbol index while locked
- pkt_done  out  1  1-cycle pulse: packet length reached

Behaviour:
- Reset values:
  - All outputs 0.
  - State IDLE.
  - Previous-symbol registers 0.
  - All counters 0.
- Processing happens only on cycles with sym_vld=1, except that priority overrides act on any cycle.
- All outputs are registered, giving 1 clk latency from the qualifying sym_vld.
- Previous-symbol registers load {sym_q, sym_i} on every sym_vld, in every state.
- Symbol classification (active lanes: I only in BPSK, I and Q in QPSK; diff = symbol XOR previous symbol):
  - TOGGLE: all active lanes differ.
  - HOLD: all active lanes are equal.
  - MIXED: anything else (QPSK only).
- Priority, highest first: rst > pd_flag=0 > disassert_bd > state logic.
- pd_flag=0: next state IDLE; bd_flag, bd_sgn, sym_idx and counters cleared.
- disassert_bd=1 while pd_flag=1: next state SEARCH; same outputs and counters cleared.
- IDLE: move to SEARCH when pd_flag=1.
- SEARCH:
  - TOGGLE: trn_cnt++ (saturating).
  - MIXED: trn_cnt <= 0.
  - HOLD with trn_cnt >= cfg_min_trn:
    - Pulse bd_init.
    - bd_sgn <= current {Q,I}; Q bit forced 0 in BPSK.
    - win_cnt <= 0, err_cnt <= 0.
    - Go to CONFIRM.
  - HOLD with trn_cnt < cfg_min_trn: trn_cnt <= 0.
- CONFIRM, on each sym_vld:
  - win_cnt++.
  - Any non-TOGGLE: err_cnt++.
  - If the new err_cnt > cfg_err_max: pulse bd_abort, clear bd_sgn, trn_cnt <= 0, go to SEARCH.
  - Else, if the new win_cnt == cfg_window: bd_flag <= 1, sym_idx <= 0, go to LOCKED.
  - Abort takes priority when both conditions occur on the same symbol.
- cfg_window = 0: SEARCH goes directly to LOCKED, with bd_init and bd_flag asserted on the same edge.
- LOCKED:
  - bd_flag held at 1.
  - sym_idx++ per sym_vld.
  - When sym_vld arrives with sym_idx == cfg_pkt_len-1 and cfg_pkt_len != 0: pulse pkt_done, clear bd_flag and sym_idx, trn_cnt <= 0, go to SEARCH.
  - cfg_pkt_len = 0: sym_idx wraps modulo 2^IDX_W; no pkt_done.
- Config inputs are sampled live. Changes take effect at the next comparison. Software changes them only in IDLE.
- bd_flag never deasserts except through the pkt_done, disassert_bd, pd_flag or rst paths.

Decomposition:
- Package rx_bd_pkg:
  - State enum: IDLE=0, SEARCH=1, CONFIRM=2, LOCKED=3.
  - Symbol-class constants: TOGGLE, HOLD, MIXED.
- Sub-module rx_bd_sym_cls:
  - Contains the previous-symbol registers and the lane-masked TOGGLE/HOLD/MIXED classifier.
  - Registered on sym_vld; reset 0.

Test Plan:
- BPSK, sym_vld=1 every cycle; cfg_min_trn=4, window=4, err_max=0, pkt_len=8; I = 1010101 1 0101… → bd_init 1 clk after the repeated 1; bd_sgn=2'b01; bd_flag 4 symbols later; sym_idx 0..7; pkt_done at idx 7; returns to SEARCH.
- Short preamble: only 2 toggles, then HOLD, with cfg_min_trn=4 → no bd_init; trn_cnt restarts at 0.
- Errors in CONFIRM: err_max=1, two HOLDs inside the window → bd_abort on the 2nd HOLD; bd_flag stays 0. The same stimulus with a single HOLD → lock.
- QPSK with mode_qpsk=1: I and Q toggle, then I holds while Q toggles (MIXED) → no boundary. Next, both lanes hold → bd_init with bd_sgn = {Q,I} of that symbol.
- Overrides:
  - pd_flag drops in LOCKED at sym_idx=3 → IDLE next clk; bd_flag=0, sym_idx=0.
  - disassert_bd during CONFIRM → SEARCH; no bd_abort.
  - rst mid-lock → all outputs 0.
- Strobe gating: sym_vld every 3rd clk, same stimulus as test 1 → identical symbol-domain results; no counter advances on sym_vld=0 cycles.
